// File: rtl/lsu_pkg.sv
// Shared LSU data-memory types: responder FSM states and byte-enable constants.
// Imported by lsu_dmem and dmem_bram_sdp.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } dmem_state_e;

    localparam int         LSU_BE_W    = 4;
    localparam logic [3:0] LSU_BE_WORD = 4'b1111;

endpackage

// File: rtl/dmem_bram_sdp.sv
// Simple dual-port RAM: one registered synchronous read port, one byte-enabled write port.
// Ports: clk/clk_en/rst, rd_en/rd_zero/rd_idx -> rd_data, wr_en/wr_idx/wr_be/wr_data.
module dmem_bram_sdp
    import lsu_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 1024,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                clk_en,
    input  logic                rst,
    input  logic                rd_en,
    input  logic                rd_zero,
    input  logic [IW-1:0]       rd_idx,
    output logic [DW-1:0]       rd_data,
    input  logic                wr_en,
    input  logic [IW-1:0]       wr_idx,
    input  logic [LSU_BE_W-1:0] wr_be,
    input  logic [DW-1:0]       wr_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clk_en && wr_en) begin
            for (int b = 0; b < LSU_BE_W; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read-first: a same-edge write is not visible to this read.
    // rd_zero forces an out-of-range read to return zero.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (rst) begin
                rd_data <= '0;
            end else if (rd_en) begin
                rd_data <= rd_zero ? '0 : mem[rd_idx];
            end
        end
    end

endmodule

// File: rtl/lsu_dmem.sv
// LSU data-memory responder: request/ack read port with WAIT_STATES, posted byte-enabled writes.
// Ports: i_clk/i_clk_en/i_rst, read (i_lsu_read, i_r_lsu_addr, o_r_lsu_data, o_lsu_ack),
// write (i_lsu_write, i_w_lsu_addr, i_w_lsu_byte_en, i_w_lsu_data), o_err when DMEM_ERR_EN defined.
module lsu_dmem
    import lsu_pkg::*;
#(
    parameter int            AW          = 32,
    parameter int            DW          = 32,
    parameter int            DEPTH_WORDS = 1024,
    parameter logic [AW-1:0] BASE_ADDR   = '0,
    parameter int            WAIT_STATES = 0
) (
    input  logic                i_clk,
    input  logic                i_clk_en,
    input  logic                i_rst,
    input  logic                i_lsu_read,
    input  logic [AW-1:0]       i_r_lsu_addr,
    output logic [DW-1:0]       o_r_lsu_data,
    output logic                o_lsu_ack,
    input  logic                i_lsu_write,
    input  logic [AW-1:0]       i_w_lsu_addr,
    input  logic [LSU_BE_W-1:0] i_w_lsu_byte_en,
`ifdef DMEM_ERR_EN
    output logic                o_err,
`endif
    input  logic [DW-1:0]       i_w_lsu_data
);

    localparam int         IW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    dmem_state_e   state, state_nx;
    logic [3:0]    cnt, cnt_nx;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] rd_addr, r_off, w_off;
    logic          r_oor, w_oor;
    logic          rd_issue;

    // In IDLE the live address feeds the RAM (zero-wait reads issue there).
    assign rd_addr = (state == IDLE) ? i_r_lsu_addr : addr_q;
    assign r_off   = rd_addr - BASE_ADDR;
    assign w_off   = i_w_lsu_addr - BASE_ADDR;

`ifdef DMEM_ERR_EN
    assign r_oor = |r_off[AW-1:IW+2];
    assign w_oor = |w_off[AW-1:IW+2];
    logic unused_bits;
    assign unused_bits = ^{r_off[1:0], w_off[1:0]};
`else
    // Upper offset bits dropped: addresses alias modulo the RAM size.
    assign r_oor = 1'b0;
    assign w_oor = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{r_off[1:0], w_off[1:0],
                           r_off[AW-1:IW+2], w_off[AW-1:IW+2]};
`endif

    // RAM read fires in the cycle just before ACK.
    assign rd_issue = ((state == IDLE) && i_lsu_read && (WS == 4'd0))
                    || ((state == WAIT) && (cnt == WS));

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (i_lsu_read) begin
                    if (WS == 4'd0) begin
                        state_nx = ACK;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = 4'd1;
                    end
                end
            end
            WAIT: begin
                if (cnt == WS) begin
                    state_nx = ACK;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            ACK: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clk_en) begin
            if (i_rst) begin
                state  <= IDLE;
                cnt    <= 4'd0;
                addr_q <= '0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
                if ((state == IDLE) && i_lsu_read) begin
                    addr_q <= i_r_lsu_addr;
                end
            end
        end
    end

    assign o_lsu_ack = (state == ACK);

`ifdef DMEM_ERR_EN
    always_ff @(posedge i_clk) begin
        if (i_clk_en) begin
            if (i_rst) begin
                o_err <= 1'b0;
            end else begin
                o_err <= rd_issue & r_oor;
            end
        end
    end
`endif

    dmem_bram_sdp #(
        .DW    (DW),
        .DEPTH (DEPTH_WORDS),
        .IW    (IW)
    ) u_ram (
        .clk     (i_clk),
        .clk_en  (i_clk_en),
        .rst     (i_rst),
        .rd_en   (rd_issue),
        .rd_zero (r_oor),
        .rd_idx  (r_off[IW+1:2]),
        .rd_data (o_r_lsu_data),
        .wr_en   (i_lsu_write & ~w_oor),
        .wr_idx  (w_off[IW+1:2]),
        .wr_be   (i_w_lsu_byte_en),
        .wr_data (i_w_lsu_data)
    );

endmodule
